// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   SZ_BYTE / SZ_HALF / SZ_WORD : access-size encodings carried on req_size
//   lsu_state_t                 : request-handling FSM states
//   size_bytes()                : byte count of a legal size encoding (0 for the illegal one)
package datamem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/datamem_lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   addr   : byte address of the access
//   size   : access size encoding
//   uns    : zero-extend (1) or sign-extend (0) narrow loads
//   wdata  : LSB-aligned store data
//   rword  : memory word containing the access (word-aligned read)
//   strb   : byte-lane write strobes within the word, zero on a fault
//   wshift : store data moved onto its byte lanes
//   fault  : illegal size, misaligned, or running past the end of memory
//   rext   : load data moved down to bit 0 and extended to 32 bits
module lsu_align
  import datamem_pkg::*;
#(
  parameter int SIZE = 4096
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strb,
  output logic [31:0] wshift,
  output logic        fault,
  output logic [31:0] rext
);

  logic [1:0]  ofs;
  logic [4:0]  sh;
  logic [32:0] end_addr;
  logic        misalign;
  logic [3:0]  base_strb;
  logic [31:0] rraw;

  // Narrow loads extend from bit 7 or 15; words pass through untouched.
  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  sz,
                                         input logic        u);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        ext;
    b = raw[7:0];
    h = raw[15:0];
    case (sz)
      SZ_BYTE: ext = u ? {24'd0, raw[7:0]}  : 32'(b);
      SZ_HALF: ext = u ? {16'd0, raw[15:0]} : 32'(h);
      default: ext = raw;
    endcase
    return ext;
  endfunction

  assign ofs      = addr[1:0];
  assign sh       = {ofs, 3'b000};
  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign end_addr = {1'b0, addr} + 33'(size_bytes(size));

  always_comb begin
    misalign  = 1'b0;
    base_strb = 4'b0000;
    case (size)
      SZ_BYTE: base_strb = 4'b0001;
      SZ_HALF: begin
        base_strb = 4'b0011;
        misalign  = addr[0];
      end
      SZ_WORD: begin
        base_strb = 4'b1111;
        misalign  = (addr[1:0] != 2'b00);
      end
      default: base_strb = 4'b0000;
    endcase
  end

  assign fault  = (size == 2'd3) | misalign | (end_addr > 33'(SIZE));
  assign strb   = fault ? 4'b0000 : (base_strb << ofs);
  assign wshift = wdata << sh;
  assign rraw   = rword >> sh;
  assign rext   = extend(rraw, size, uns);

endmodule

// File: rtl/datamem_lsu.sv
// datamem_lsu: byte-addressed data memory behind a valid/ready load/store port
// with a fixed response latency and one request in flight.
//   clk, rst_n       : clock, asynchronous active-low reset (memory is not reset)
//   req_valid/ready  : request handshake; ready only while idle
//   req_we           : 1 = store, 0 = load
//   req_addr         : byte address
//   req_size         : 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned     : zero-extend narrow loads when 1
//   req_wdata        : LSB-aligned store data
//   rsp_valid/ready  : response handshake; response held until consumed
//   rsp_rdata        : extended load data, 0 for stores and faults
//   rsp_err          : access fault
module datamem_lsu
  import datamem_pkg::*;
#(
  parameter int SIZE    = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(SIZE);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  logic [7:0]  mem [SIZE];

  lsu_state_t  state;
  logic [2:0]  cnt;
  logic        rdy_q;
  logic        vld_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        acc;
  logic [AW-1:0] wbase;
  logic [31:0] rword;
  logic [3:0]  strb;
  logic [31:0] wshift;
  logic        fault;
  logic [31:0] rext;

  assign acc   = req_valid & rdy_q;
  assign wbase = req_addr[AW-1:0] & ~(AW'(3));

  // Word containing the addressed byte; out-of-range addresses alias here
  // but are faulted, so their data never reaches the response.
  always_comb begin
    rword = '0;
    for (int k = 0; k < 4; k++) begin
      rword[8*k +: 8] = mem[wbase | AW'(k)];
    end
  end

  lsu_align #(.SIZE(SIZE)) u_align (
    .addr   (req_addr),
    .size   (req_size),
    .uns    (req_unsigned),
    .wdata  (req_wdata),
    .rword  (rword),
    .strb   (strb),
    .wshift (wshift),
    .fault  (fault),
    .rext   (rext)
  );

  // Store commits on the accept edge; a later reset cannot undo it.
  always_ff @(posedge clk) begin
    if (acc && req_we && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) mem[wbase | AW'(k)] <= wshift[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            rdata_q <= (req_we || fault) ? 32'd0 : rext;
            err_q   <= fault;
            cnt     <= CNT_INIT;
            rdy_q   <= 1'b0;
            if (LATENCY > 1) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_RESP;
              vld_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // Leave on the edge that takes the counter to zero, so the
          // response appears exactly LATENCY edges after the accept.
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ST_RESP;
            vld_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_datamem_lsu.sv
module tb_datamem_lsu;

  localparam int SZ = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][1:0]  req_size;
  logic [1:0]       req_unsigned;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;

  datamem_lsu #(.SIZE(SZ), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  datamem_lsu #(.SIZE(SZ), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int ncomp = 0;
  int nfail = 0;
  int lat [2] = '{1, 4};
  logic [7:0]  ref_mem [2][SZ];
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain byte array, little-endian, faults from the access rules.
  task automatic model(input int w, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata);
    longint a, v, n;
    a = longint'(addr);
    rdata = 32'd0;
    if (size == 2'd3) err = 1'b1;
    else begin
      n = longint'(1) << size;
      err = ((a % n) != 0) || (a + n > SZ);
    end
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[w][a + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[w][a + i]) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic drive(input int w, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    req_valid[w] = 1'b1; req_we[w] = we; req_addr[w] = addr;
    req_size[w] = size; req_unsigned[w] = uns; req_wdata[w] = wdata;
  endtask

  // Junk store held on the port while not ready; it must be ignored.
  task automatic junk(input int w);
    drive(w, 1'b1, $urandom_range(0, SZ - 1) & ~32'd3, 2'd2, 1'b0, $urandom);
  endtask

  task automatic txn(input int w, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          cyc;
    @(negedge clk);
    rsp_ready[w] = 1'b0;
    check("req_ready_idle", 32'(req_ready[w]), 32'd1);
    drive(w, we, addr, size, uns, wdata);
    model(w, we, addr, size, uns, wdata, e_err, e_rd);
    @(posedge clk);
    @(negedge clk);
    junk(w);
    cyc = 1;
    while (!rsp_valid[w] && cyc < 20) begin
      check("req_ready_busy", 32'(req_ready[w]), 32'd0);
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat[w]));
    check("rsp_err", 32'(rsp_err[w]), 32'(e_err));
    check("rsp_rdata", rsp_rdata[w], e_rd);
    last_rdata = rsp_rdata[w];
    last_err   = rsp_err[w];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[w]), 32'd1);
      check("hold_rdata", rsp_rdata[w], e_rd);
      check("hold_ready", 32'(req_ready[w]), 32'd0);
    end
    rsp_ready[w] = 1'b1;
    req_valid[w] = 1'b0;
    @(posedge clk);
  endtask

  // Accept a request, then pulse reset while it is still in WAIT.
  task automatic abort_in_wait(input int w, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    logic        e_err;
    logic [31:0] e_rd;
    @(negedge clk);
    rsp_ready[w] = 1'b1;
    check("abort_ready", 32'(req_ready[w]), 32'd1);
    drive(w, we, addr, 2'd2, 1'b0, wdata);
    model(w, we, addr, 2'd2, 1'b0, wdata, e_err, e_rd);
    @(posedge clk);
    @(negedge clk);
    req_valid[w] = 1'b0;
    @(negedge clk);
    rst_n[w] = 1'b0;
    #1;
    check("abort_rst_valid", 32'(rsp_valid[w]), 32'd0);
    check("abort_rst_rdata", rsp_rdata[w], 32'd0);
    @(negedge clk);
    rst_n[w] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid[w]), 32'd0);
      check("abort_ready_after", 32'(req_ready[w]), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n_rand;
    logic [1:0]  sz;
    logic [31:0] ad;
    rst_n = 2'b00; req_valid = '0; rsp_ready = '0;
    req_we = '0; req_addr = '0; req_size = '0; req_unsigned = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check("rst_valid", 32'(rsp_valid[w]), 32'd0);
      check("rst_rdata", rsp_rdata[w], 32'd0);
      check("rst_err", 32'(rsp_err[w]), 32'd0);
    end
    rst_n = 2'b11;
    @(negedge clk);
    for (int w = 0; w < 2; w++) check("rst_ready", 32'(req_ready[w]), 32'd1);

    // Fill both memories so every later load has a defined value.
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < SZ; a += 4) txn(w, 1'b1, 32'(a), 2'd2, 1'b0, $urandom, 0);

    // Directed, latency 1.
    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0);
    check("dir_word_load", last_rdata, 32'hDEADBEEF);
    check("dir_word_err", 32'(last_err), 32'd0);
    txn(0, 1'b1, 32'h11, 2'd0, 1'b0, 32'h00000080, 0);
    txn(0, 1'b0, 32'h11, 2'd0, 1'b0, 32'd0, 0);
    check("dir_sbyte", last_rdata, 32'hFFFFFF80);
    txn(0, 1'b0, 32'h10, 2'd1, 1'b1, 32'd0, 0);
    check("dir_uhalf", last_rdata, 32'h000080EF);
    txn(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'd0, 0);
    check("dir_shalf", last_rdata, 32'hFFFFDEAD);
    txn(0, 1'b1, 32'h12, 2'd2, 1'b0, 32'h12345678, 0);
    check("dir_mis_err", 32'(last_err), 32'd1);
    check("dir_mis_rdata", last_rdata, 32'd0);
    txn(0, 1'b0, 32'h10, 2'd2, 1'b1, 32'd0, 0);
    check("dir_after_mis", last_rdata, 32'hDEAD80EF);
    txn(0, 1'b0, 32'(SZ - 2), 2'd2, 1'b0, 32'd0, 0);
    check("dir_end_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'(SZ), 2'd0, 1'b0, 32'd0, 0);
    check("dir_oob_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'(SZ - 4), 2'd2, 1'b0, 32'd0, 0);
    check("dir_last_word_ok", 32'(last_err), 32'd0);
    txn(0, 1'b1, 32'h20, 2'd3, 1'b0, 32'hCAFEF00D, 0);
    check("dir_sz3_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0);

    // Directed, latency 4: response held while rsp_ready is low.
    txn(1, 1'b1, 32'h40, 2'd2, 1'b0, 32'hA5C3_0F81, 0);
    txn(1, 1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 3);
    check("l4_hold_load", last_rdata, 32'hA5C30F81);
    txn(1, 1'b0, 32'h43, 2'd0, 1'b1, 32'd0, 0);
    check("l4_ubyte", last_rdata, 32'h000000A5);

    // Reset mid-operation: committed store survives, response is dropped.
    abort_in_wait(1, 1'b1, 32'h50, 32'h0BADCAFE);
    txn(1, 1'b0, 32'h50, 2'd2, 1'b0, 32'd0, 0);
    check("abort_store_kept", last_rdata, 32'h0BADCAFE);
    abort_in_wait(1, 1'b0, 32'h50, 32'd0);
    txn(1, 1'b0, 32'h50, 2'd2, 1'b0, 32'd0, 0);

    // Randomized traffic against the byte-array model.
    for (int w = 0; w < 2; w++) begin
      n_rand = (w == 0) ? 150 : 100;
      for (int i = 0; i < n_rand; i++) begin
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        ad = $urandom_range(0, SZ + 7);
        if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
        txn(w, 1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
